reg_bank_router: RTL and testbench

//  Sequences the simple register interface of axi_lite_slave across NUM_BANKS register banks.

---
 rtl/reg_bank_router_pkg.sv | 19 +
 rtl/reg_bank_router_decode.sv | 27 ++
 rtl/reg_bank_router.sv | 155 +++++++++++++++
 tb/tb_reg_bank_router.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_router_pkg.sv
// Shared constants for reg_bank_router: FSM state encodings and an index-width helper.
package reg_bank_router_pkg;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWait    = 2'd1;
  localparam logic [1:0] StResp    = 2'd2;
  localparam logic [1:0] StRelease = 2'd3;

  // Bits needed to index n items, never less than 1 so single-bank builds keep a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_bank_router_decode.sv
// Combinational upstream address decode: bank index, one-hot bank select and out-of-range flag.
module reg_bank_router_decode
  import reg_bank_router_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned BANK_ADDR_BITS = 8,
  localparam int unsigned IdxW          = idx_width(NUM_BANKS)
) (
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [IdxW-1:0]       idx,
  output logic [NUM_BANKS-1:0]  onehot,
  output logic                  out_of_range
);

  logic [ADDR_WIDTH-1:0] bank_num;

  assign bank_num     = address >> BANK_ADDR_BITS;
  assign out_of_range = (bank_num >= ADDR_WIDTH'(NUM_BANKS));
  assign idx          = bank_num[IdxW-1:0];

  always_comb begin
    onehot = '0;
    if (!out_of_range) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_router.sv
// Routes one upstream register transaction at a time to one of NUM_BANKS banks.
// Optional bank-response timeout enabled by defining REG_ROUTER_TIMEOUT_EN.
module reg_bank_router
  import reg_bank_router_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned BANK_ADDR_BITS = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                            i_axi_clk,
  input  logic                            i_axi_rst,
  input  logic [ADDR_WIDTH-1:0]           i_reg_address,
  input  logic                            i_reg_in_rdy,
  input  logic [DATA_WIDTH-1:0]           i_reg_in_data,
  output logic                            o_reg_in_ack,
  input  logic                            i_reg_out_req,
  output logic                            o_reg_out_rdy,
  output logic [DATA_WIDTH-1:0]           o_reg_out_data,
  output logic                            o_reg_invalid_addr,
  output logic [BANK_ADDR_BITS-1:0]       o_bank_address,
  output logic [DATA_WIDTH-1:0]           o_bank_in_data,
  output logic [NUM_BANKS-1:0]            o_bank_in_rdy,
  input  logic [NUM_BANKS-1:0]            i_bank_in_ack,
  output logic [NUM_BANKS-1:0]            o_bank_out_req,
  input  logic [NUM_BANKS-1:0]            i_bank_out_rdy,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_bank_out_data,
  input  logic [NUM_BANKS-1:0]            i_bank_invalid_addr
);

  localparam int unsigned IdxW = idx_width(NUM_BANKS);

  logic [1:0]                state_q, state_d;
  logic                      wr_q, wr_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [NUM_BANKS-1:0]      sel_q, sel_d;
  logic [BANK_ADDR_BITS-1:0] offs_q, offs_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      inv_q, inv_d;

  logic [IdxW-1:0]           dec_idx;
  logic [NUM_BANKS-1:0]      dec_onehot;
  logic                      dec_oor;
  logic                      ack_hit;
  logic                      bank_inv;
  logic [DATA_WIDTH-1:0]     bank_rdata;
  logic                      timeout;

  reg_bank_router_decode #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NUM_BANKS      (NUM_BANKS),
    .BANK_ADDR_BITS (BANK_ADDR_BITS)
  ) u_decode (
    .address      (i_reg_address),
    .idx          (dec_idx),
    .onehot       (dec_onehot),
    .out_of_range (dec_oor)
  );

  // Only the selected bank's answer in the serviced direction counts.
  assign ack_hit    = wr_q ? |(i_bank_in_ack & sel_q) : |(i_bank_out_rdy & sel_q);
  assign bank_inv   = i_bank_invalid_addr[idx_q];
  assign bank_rdata = i_bank_out_data[idx_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef REG_ROUTER_TIMEOUT_EN
  localparam int unsigned CntW = idx_width(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign cnt_d   = (state_q == StWait) ? cnt_q + 1'b1 : '0;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    offs_d  = offs_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    inv_d   = inv_q;
    case (state_q)
      StIdle: begin
        if (i_reg_in_rdy || i_reg_out_req) begin
          wr_d    = i_reg_in_rdy;
          idx_d   = dec_idx;
          sel_d   = dec_onehot;
          offs_d  = i_reg_address[BANK_ADDR_BITS-1:0];
          wdata_d = i_reg_in_data;
          rdata_d = '0;
          inv_d   = dec_oor;
          state_d = dec_oor ? StResp : StWait;
        end
      end
      StWait: begin
        // A real answer beats a timeout landing in the same cycle.
        if (ack_hit) begin
          inv_d   = bank_inv;
          rdata_d = wr_q ? '0 : bank_rdata;
          state_d = StResp;
        end else if (timeout) begin
          inv_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end
      end
      StResp: state_d = StRelease;
      default: begin
        if (wr_q ? !i_reg_in_rdy : !i_reg_out_req) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q <= StIdle;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      offs_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      offs_q  <= offs_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      inv_q   <= inv_d;
    end
  end

  assign o_bank_address     = offs_q;
  assign o_bank_in_data     = wdata_q;
  assign o_bank_in_rdy      = (state_q == StWait && wr_q)  ? sel_q : '0;
  assign o_bank_out_req     = (state_q == StWait && !wr_q) ? sel_q : '0;
  assign o_reg_in_ack       = (state_q == StResp) && wr_q;
  assign o_reg_out_rdy      = (state_q == StResp) && !wr_q;
  assign o_reg_out_data     = (state_q == StResp) ? rdata_q : '0;
  assign o_reg_invalid_addr = (state_q == StResp) && inv_q;

endmodule

// File: tb/tb_reg_bank_router.sv
// Self-checking bench for reg_bank_router; define REG_ROUTER_TIMEOUT_EN to also cover the timeout.
module tb_reg_bank_router;

  localparam int NB  = 4;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int BAB = 8;
  localparam int TO  = 16;

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     reg_address;
  logic              reg_in_rdy;
  logic [DW-1:0]     reg_in_data;
  logic              reg_in_ack;
  logic              reg_out_req;
  logic              reg_out_rdy;
  logic [DW-1:0]     reg_out_data;
  logic              reg_invalid;
  logic [BAB-1:0]    bank_address;
  logic [DW-1:0]     bank_in_data;
  logic [NB-1:0]     bank_in_rdy;
  logic [NB-1:0]     bank_in_ack;
  logic [NB-1:0]     bank_out_req;
  logic [NB-1:0]     bank_out_rdy;
  logic [NB*DW-1:0]  bank_out_data;
  logic [NB-1:0]     bank_invalid;

  int checks;
  int failures;

  // Observations from the most recent run_txn.
  int          ob_scyc;
  logic [3:0]  ob_wrs;
  logic [3:0]  ob_rds;
  bit          ob_stable;
  int          ob_pcyc;
  int          ob_pcnt;
  bit          ob_dirok;
  logic [31:0] ob_data;
  logic        ob_inv;

  reg_bank_router #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_BANKS      (NB),
    .BANK_ADDR_BITS (BAB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_axi_clk           (clk),
    .i_axi_rst           (rst_n),
    .i_reg_address       (reg_address),
    .i_reg_in_rdy        (reg_in_rdy),
    .i_reg_in_data       (reg_in_data),
    .o_reg_in_ack        (reg_in_ack),
    .i_reg_out_req       (reg_out_req),
    .o_reg_out_rdy       (reg_out_rdy),
    .o_reg_out_data      (reg_out_data),
    .o_reg_invalid_addr  (reg_invalid),
    .o_bank_address      (bank_address),
    .o_bank_in_data      (bank_in_data),
    .o_bank_in_rdy       (bank_in_rdy),
    .i_bank_in_ack       (bank_in_ack),
    .o_bank_out_req      (bank_out_req),
    .i_bank_out_rdy      (bank_out_rdy),
    .i_bank_out_data     (bank_out_data),
    .i_bank_invalid_addr (bank_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plays the upstream master and all banks for one transaction. The selected bank answers in
  // its ans-th strobe cycle (ans=0: never). With noise, other banks and the wrong direction
  // chatter on every earlier strobe cycle.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input int ans, input logic [31:0] rdata, input bit rinv,
                         input bit noise);
    int         idx;
    int         tail;
    logic [3:0] sel;
    idx = int'(addr >> 8);
    sel = (idx < NB) ? (4'b0001 << idx) : 4'b0000;
    ob_scyc = 0; ob_wrs = '0; ob_rds = '0; ob_stable = 1'b1; ob_pcyc = -1; ob_pcnt = 0;
    ob_dirok = 1'b1; ob_data = '0; ob_inv = 1'b0;
    bank_out_data = {$urandom, $urandom, $urandom, $urandom};
    if (idx < NB) bank_out_data[idx*DW +: DW] = rdata;
    @(posedge clk); #1;
    reg_address = addr; reg_in_data = wdata; reg_in_rdy = wr; reg_out_req = !wr;
    tail = 0;
    for (int cyc = 1; cyc <= 300 && tail < 4; cyc++) begin
      @(posedge clk); #1;
      bank_in_ack = '0; bank_out_rdy = '0; bank_invalid = '0;
      if (bank_in_rdy != 0 || bank_out_req != 0) begin
        ob_scyc++;
        ob_wrs |= bank_in_rdy;
        ob_rds |= bank_out_req;
        if (bank_address !== addr[7:0]) ob_stable = 1'b0;
        if (wr && bank_in_data !== wdata) ob_stable = 1'b0;
        if (ob_scyc == ans && idx < NB) begin
          if (wr) bank_in_ack[idx] = 1'b1;
          else    bank_out_rdy[idx] = 1'b1;
          bank_invalid[idx] = rinv;
        end else if (noise) begin
          bank_in_ack  = ~sel | (wr ? 4'b0000 : sel);
          bank_out_rdy = ~sel | (wr ? sel : 4'b0000);
          bank_invalid = 4'hF;
        end
      end
      if (reg_in_ack || reg_out_rdy) begin
        ob_pcnt++;
        if (ob_pcyc < 0) begin
          ob_pcyc = cyc; ob_data = reg_out_data; ob_inv = reg_invalid;
        end
        if (reg_in_ack !== wr || reg_out_rdy !== !wr) ob_dirok = 1'b0;
        reg_in_rdy = 1'b0; reg_out_req = 1'b0;
      end
      if (ob_pcyc >= 0) tail++;
    end
    bank_in_ack = '0; bank_out_rdy = '0; bank_invalid = '0;
    reg_in_rdy = 1'b0; reg_out_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reg_address = '0; reg_in_rdy = 1'b0; reg_in_data = '0; reg_out_req = 1'b0;
    bank_in_ack = '0; bank_out_rdy = '0; bank_out_data = '0; bank_invalid = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({reg_in_ack, reg_out_rdy, reg_out_data, reg_invalid} !== '0) begin
      failures++;
      $display("FAIL reset_upstream got=%0h exp=0", {reg_in_ack, reg_out_rdy, reg_out_data, reg_invalid});
    end
    checks++;
    if ({bank_address, bank_in_data, bank_in_rdy, bank_out_req} !== '0) begin
      failures++;
      $display("FAIL reset_bank got=%0h exp=0", {bank_address, bank_in_data, bank_in_rdy, bank_out_req});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({reg_in_ack, reg_out_rdy, bank_in_rdy, bank_out_req} !== '0) begin
      failures++;
      $display("FAIL reset_release_idle got=%0h exp=0", {reg_in_ack, reg_out_rdy, bank_in_rdy, bank_out_req});
    end
  endtask

  task automatic test_write_bank1();
    run_txn(1'b1, 16'h0104, 32'hA5A5_0001, 3, 32'h0, 1'b0, 1'b0);
    checks++;
    if (ob_scyc !== 3) begin failures++; $display("FAIL wr1_strobe_cycles got=%0d exp=3", ob_scyc); end
    checks++;
    if (ob_wrs !== 4'b0010 || ob_rds !== 4'b0000) begin
      failures++; $display("FAIL wr1_strobe got=%b/%b exp=0010/0000", ob_wrs, ob_rds);
    end
    checks++;
    if (ob_stable !== 1'b1) begin failures++; $display("FAIL wr1_addr_data_stable got=0 exp=1"); end
    checks++;
    if (ob_pcyc !== 4 || ob_pcnt !== 1 || ob_dirok !== 1'b1) begin
      failures++; $display("FAIL wr1_ack_pulse got=cyc%0d n%0d dir%0d exp=cyc4 n1 dir1", ob_pcyc, ob_pcnt, ob_dirok);
    end
    checks++;
    if (ob_inv !== 1'b0) begin failures++; $display("FAIL wr1_invalid got=%b exp=0", ob_inv); end
  endtask

  task automatic test_read_invalid();
    run_txn(1'b0, 16'h0308, 32'h0, 2, 32'h1234_5678, 1'b1, 1'b0);
    checks++;
    if (ob_rds !== 4'b1000 || ob_wrs !== 4'b0000) begin
      failures++; $display("FAIL rd3_strobe got=%b/%b exp=1000/0000", ob_rds, ob_wrs);
    end
    checks++;
    if (ob_pcyc !== 3 || ob_pcnt !== 1 || ob_dirok !== 1'b1) begin
      failures++; $display("FAIL rd3_rdy_pulse got=cyc%0d n%0d dir%0d exp=cyc3 n1 dir1", ob_pcyc, ob_pcnt, ob_dirok);
    end
    checks++;
    if (ob_data !== 32'h1234_5678 || ob_inv !== 1'b1) begin
      failures++; $display("FAIL rd3_data_inv got=%h/%b exp=12345678/1", ob_data, ob_inv);
    end
  endtask

  task automatic test_out_of_range();
    run_txn(1'b1, 16'h0400, 32'hDEAD_BEEF, 1, 32'h0, 1'b0, 1'b0);
    checks++;
    if (ob_scyc !== 0 || ob_pcyc !== 1 || ob_inv !== 1'b1 || ob_dirok !== 1'b1) begin
      failures++;
      $display("FAIL oor_write got=strb%0d cyc%0d inv%b exp=strb0 cyc1 inv1", ob_scyc, ob_pcyc, ob_inv);
    end
    run_txn(1'b0, 16'h0400, 32'h0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checks++;
    if (ob_scyc !== 0 || ob_pcyc !== 1 || ob_inv !== 1'b1 || ob_data !== 32'h0 || ob_dirok !== 1'b1) begin
      failures++;
      $display("FAIL oor_read got=strb%0d cyc%0d inv%b data%h exp=strb0 cyc1 inv1 data0", ob_scyc, ob_pcyc,
               ob_inv, ob_data);
    end
  endtask

  task automatic test_priority();
    bit saw;
    int k;
    bank_out_data = '0;
    bank_out_data[2*DW +: DW] = 32'h0BAD_F00D;
    @(posedge clk); #1;
    reg_address = 16'h0204; reg_in_data = 32'h5555_AAAA; reg_in_rdy = 1'b1; reg_out_req = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bank_in_rdy !== 4'b0100 || bank_out_req !== 4'b0000) begin
      failures++; $display("FAIL prio_write_first got=%b/%b exp=0100/0000", bank_in_rdy, bank_out_req);
    end
    bank_in_ack[2] = 1'b1;
    @(posedge clk); #1;
    bank_in_ack = '0;
    checks++;
    if (reg_in_ack !== 1'b1 || reg_out_rdy !== 1'b0) begin
      failures++; $display("FAIL prio_write_ack got=%b/%b exp=1/0", reg_in_ack, reg_out_rdy);
    end
    saw = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bank_in_rdy != 0 || bank_out_req != 0 || reg_in_ack || reg_out_rdy) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin failures++; $display("FAIL prio_hold_no_service got=1 exp=0"); end
    reg_in_rdy = 1'b0;
    k = 0;
    for (int c = 1; c <= 10 && k == 0; c++) begin
      @(posedge clk); #1;
      if (bank_out_req == 4'b0100) k = c;
    end
    checks++;
    if (k !== 2) begin failures++; $display("FAIL prio_read_start got=%0d exp=2", k); end
    bank_out_rdy[2] = 1'b1;
    @(posedge clk); #1;
    bank_out_rdy = '0;
    checks++;
    if (reg_out_rdy !== 1'b1 || reg_out_data !== 32'h0BAD_F00D || reg_invalid !== 1'b0) begin
      failures++;
      $display("FAIL prio_read_done got=%b/%h/%b exp=1/0badf00d/0", reg_out_rdy, reg_out_data, reg_invalid);
    end
    reg_out_req = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_ignore_others();
    run_txn(1'b1, 16'h0010, 32'h0000_0077, 4, 32'h0, 1'b0, 1'b1);
    checks++;
    if (ob_scyc !== 4 || ob_pcyc !== 5 || ob_pcnt !== 1) begin
      failures++; $display("FAIL noise_wr got=strb%0d cyc%0d n%0d exp=strb4 cyc5 n1", ob_scyc, ob_pcyc, ob_pcnt);
    end
    checks++;
    if (ob_wrs !== 4'b0001 || ob_inv !== 1'b0) begin
      failures++; $display("FAIL noise_wr_sel got=%b/%b exp=0001/0", ob_wrs, ob_inv);
    end
    run_txn(1'b0, 16'h02FC, 32'h0, 3, 32'hCAFE_0002, 1'b0, 1'b1);
    checks++;
    if (ob_pcyc !== 4 || ob_data !== 32'hCAFE_0002 || ob_inv !== 1'b0 || ob_dirok !== 1'b1) begin
      failures++; $display("FAIL noise_rd got=cyc%0d %h/%b exp=cyc4 cafe0002/0", ob_pcyc, ob_data, ob_inv);
    end
  endtask

  task automatic test_random();
    bit          wr, rinv, noise, oor;
    logic [15:0] addr;
    logic [31:0] wdata, rdata, exp_data;
    logic [3:0]  exp_sel;
    int          ans, exp_pcyc, exp_scyc;
    for (int n = 0; n < 24; n++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h04FF));
      wdata = $urandom;
      rdata = $urandom;
      rinv  = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      ans   = $urandom_range(1, 5);
      // Model: window k covers [k*256, k*256+255]; anything from NB*256 up is invalid.
      oor      = (int'(addr) >= NB * 256);
      exp_sel  = oor ? 4'b0000 : 4'(1 << (int'(addr) / 256));
      exp_scyc = oor ? 0 : ans;
      exp_pcyc = oor ? 1 : ans + 1;
      exp_data = (oor || wr) ? 32'h0 : rdata;
      run_txn(wr, addr, wdata, ans, rdata, rinv, noise);
      checks++;
      if (ob_pcyc !== exp_pcyc || ob_pcnt !== 1 || ob_dirok !== 1'b1) begin
        failures++;
        $display("FAIL rnd%0d_pulse addr=%h wr=%b got=cyc%0d n%0d dir%0d exp=cyc%0d n1 dir1", n, addr, wr,
                 ob_pcyc, ob_pcnt, ob_dirok, exp_pcyc);
      end
      checks++;
      if (ob_scyc !== exp_scyc || ob_wrs !== (wr ? exp_sel : 4'b0) || ob_rds !== (wr ? 4'b0 : exp_sel)) begin
        failures++;
        $display("FAIL rnd%0d_strobe addr=%h got=%0d %b/%b exp=%0d sel=%b", n, addr, ob_scyc, ob_wrs, ob_rds,
                 exp_scyc, exp_sel);
      end
      checks++;
      if (ob_inv !== (oor ? 1'b1 : rinv) || ob_stable !== 1'b1) begin
        failures++; $display("FAIL rnd%0d_inv_stable addr=%h got=%b/%b exp=%b/1", n, addr, ob_inv, ob_stable,
                             oor ? 1'b1 : rinv);
      end
      if (!wr) begin
        checks++;
        if (ob_data !== exp_data) begin
          failures++; $display("FAIL rnd%0d_rdata addr=%h got=%h exp=%h", n, addr, ob_data, exp_data);
        end
      end
    end
  endtask

`ifdef REG_ROUTER_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(1'b1, 16'h0204, 32'h1111_2222, 0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (ob_scyc !== TO || ob_pcyc !== TO + 1 || ob_inv !== 1'b1 || ob_dirok !== 1'b1) begin
      failures++;
      $display("FAIL timeout_wr got=strb%0d cyc%0d inv%b exp=strb%0d cyc%0d inv1", ob_scyc, ob_pcyc, ob_inv,
               TO, TO + 1);
    end
    run_txn(1'b0, 16'h0104, 32'h0, 0, 32'hABCD_EF01, 1'b0, 1'b0);
    checks++;
    if (ob_scyc !== TO || ob_inv !== 1'b1 || ob_data !== 32'h0) begin
      failures++; $display("FAIL timeout_rd got=strb%0d inv%b data%h exp=strb%0d inv1 data0", ob_scyc, ob_inv,
                           ob_data, TO);
    end
    run_txn(1'b0, 16'h0300, 32'h0, TO, 32'h7777_8888, 1'b0, 1'b0);
    checks++;
    if (ob_pcyc !== TO + 1 || ob_inv !== 1'b0 || ob_data !== 32'h7777_8888) begin
      failures++; $display("FAIL timeout_edge_answer got=cyc%0d inv%b data%h exp=cyc%0d inv0 data77778888",
                           ob_pcyc, ob_inv, ob_data, TO + 1);
    end
  endtask
`endif

  task automatic test_reset_mid_wait();
    bit saw;
    @(posedge clk); #1;
    reg_address = 16'h0344; reg_out_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bank_out_req !== 4'b1000) begin
      failures++; $display("FAIL midrst_wait_strobe got=%b exp=1000", bank_out_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bank_in_rdy, bank_out_req, bank_address, bank_in_data, reg_in_ack, reg_out_rdy, reg_out_data,
         reg_invalid} !== '0) begin
      failures++; $display("FAIL midrst_outputs got=%b/%b/%h exp=all zero", bank_out_req, reg_out_rdy,
                           bank_address);
    end
    reg_out_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (reg_in_ack || reg_out_rdy || bank_in_rdy != 0 || bank_out_req != 0) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin failures++; $display("FAIL midrst_no_pulse got=1 exp=0"); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_bank1();
    test_read_invalid();
    test_out_of_range();
    test_priority();
    test_ignore_others();
    test_random();
`ifdef REG_ROUTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
